// File: rtl/regfile_mp.sv
// Multi-port integer register file with busy scoreboard and a post-reset clear sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and busy clears to the read ports.
module regfile_mp #(
  parameter  int RegWidth = 32,
  parameter  int RegDepth = 32,
  parameter  int NumRead  = 2,
  parameter  int NumWrite = 2,
  localparam int AddrW    = $clog2(RegDepth)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  output logic                         ready_o,
  input  logic [NumRead*AddrW-1:0]     rd_addr_i,
  output logic [NumRead*RegWidth-1:0]  rd_data_o,
  output logic [NumRead-1:0]           busy_o,
  input  logic [NumWrite-1:0]          wr_en_i,
  input  logic [NumWrite*AddrW-1:0]    wr_addr_i,
  input  logic [NumWrite*RegWidth-1:0] wr_data_i,
  input  logic                         resv_en_i,
  input  logic [AddrW-1:0]             resv_addr_i
);

  typedef enum logic {CLEAR, RUN} state_e;

  localparam logic [AddrW-1:0] LastReg = AddrW'(RegDepth - 1);

  state_e               state_q, state_d;
  logic [AddrW-1:0]     cnt_q;
  logic [RegWidth-1:0]  regs_q [1:RegDepth-1];
  logic [RegDepth-1:0]  busy_q;

  logic [AddrW-1:0]     rd_addr [NumRead];
  logic [RegWidth-1:0]  rd_data [NumRead];
  logic [AddrW-1:0]     wr_addr [NumWrite];
  logic [RegWidth-1:0]  wr_data [NumWrite];

  for (genvar r = 0; r < NumRead; r++) begin : g_rd
    assign rd_addr[r] = rd_addr_i[r*AddrW +: AddrW];
    assign rd_data_o[r*RegWidth +: RegWidth] = rd_data[r];
  end

  for (genvar k = 0; k < NumWrite; k++) begin : g_wr
    assign wr_addr[k] = wr_addr_i[k*AddrW +: AddrW];
    assign wr_data[k] = wr_data_i[k*RegWidth +: RegWidth];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (cnt_q == LastReg) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  assign ready_o = (state_q == RUN);

  // Control state: FSM, sweep counter and scoreboard are reset; storage is not.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= CLEAR;
      cnt_q   <= AddrW'(1);
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        for (int k = 0; k < NumWrite; k++) begin
          if (wr_en_i[k] && wr_addr[k] != '0) busy_q[wr_addr[k]] <= 1'b0;
        end
        // Reservation is for a younger instruction, so it overrides a same-cycle clear.
        if (resv_en_i && resv_addr_i != '0) busy_q[resv_addr_i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      if (state_q == CLEAR) begin
        regs_q[cnt_q] <= '0;
      end else begin
        // Ascending loop: highest-index port wins on address collisions.
        for (int k = 0; k < NumWrite; k++) begin
          if (wr_en_i[k] && wr_addr[k] != '0) regs_q[wr_addr[k]] <= wr_data[k];
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NumRead; r++) begin
      rd_data[r] = '0;
      busy_o[r]  = 1'b0;
      if (state_q == RUN && rd_addr[r] != '0) begin
        rd_data[r] = regs_q[rd_addr[r]];
        busy_o[r]  = busy_q[rd_addr[r]];
`ifdef REGFILE_BYPASS_EN
        for (int k = 0; k < NumWrite; k++) begin
          if (wr_en_i[k] && wr_addr[k] == rd_addr[r]) begin
            rd_data[r] = wr_data[k];
            busy_o[r]  = resv_en_i && (resv_addr_i == rd_addr[r]);
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised bench for regfile_mp against an array-based reference model, plus directed
// literal checks for sweep timing, write priority, x0 and the busy scoreboard.
module tb_regfile_mp;
  localparam int DW = 32, DEPTH = 32, NR = 2, NW = 2, AW = 5;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              ready_o;
  logic [NR*AW-1:0]  rd_addr_i = '0;
  logic [NR*DW-1:0]  rd_data_o;
  logic [NR-1:0]     busy_o;
  logic [NW-1:0]     wr_en_i = '0;
  logic [NW*AW-1:0]  wr_addr_i = '0;
  logic [NW*DW-1:0]  wr_data_i = '0;
  logic              resv_en_i = 1'b0;
  logic [AW-1:0]     resv_addr_i = '0;

  regfile_mp #(.RegWidth(DW), .RegDepth(DEPTH), .NumRead(NR), .NumWrite(NW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .ready_o(ready_o),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .busy_o(busy_o),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .resv_en_i(resv_en_i), .resv_addr_i(resv_addr_i)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: contents, busy flags, cycles since reset release.
  logic [DW-1:0] m_regs [DEPTH];
  bit            m_busy [DEPTH];
  int            rel = 0;
  bit            seen = 1'b0;

  function automatic bit m_ready();
    return seen && rel >= DEPTH - 1;
  endfunction

  function automatic logic [DW-1:0] exp_rd(input int r);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    a = rd_addr_i[r*AW +: AW];
    if (!m_ready() || a == 0) return '0;
    d = m_regs[a];
`ifdef REGFILE_BYPASS_EN
    for (int k = 0; k < NW; k++)
      if (wr_en_i[k] && wr_addr_i[k*AW +: AW] == a) d = wr_data_i[k*DW +: DW];
`endif
    return d;
  endfunction

  function automatic bit exp_busy(input int r);
    logic [AW-1:0] a;
    bit b;
    a = rd_addr_i[r*AW +: AW];
    if (!m_ready() || a == 0) return 1'b0;
    b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
    for (int k = 0; k < NW; k++)
      if (wr_en_i[k] && wr_addr_i[k*AW +: AW] == a) b = resv_en_i && (resv_addr_i == a);
`endif
    return b;
  endfunction

  always @(posedge clk_i) begin
    if (!rst_ni) begin
      seen = 1'b1;
      rel  = 0;
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
    end else if (seen) begin
      if (rel < DEPTH - 1) begin
        rel++;
        if (rel == DEPTH - 1) for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
      end else begin
        for (int k = 0; k < NW; k++) begin
          if (wr_en_i[k] && wr_addr_i[k*AW +: AW] != 0) begin
            m_regs[wr_addr_i[k*AW +: AW]] = wr_data_i[k*DW +: DW];
            m_busy[wr_addr_i[k*AW +: AW]] = 1'b0;
          end
        end
        if (resv_en_i && resv_addr_i != 0) m_busy[resv_addr_i] = 1'b1;
      end
    end
  end

  always @(negedge clk_i) begin
    if (seen) begin
      chk("ready", 64'(ready_o), 64'(m_ready()));
      for (int r = 0; r < NR; r++) begin
        chk("rd_data", 64'(rd_data_o[r*DW +: DW]), 64'(exp_rd(r)));
        chk("busy", 64'(busy_o[r]), 64'(exp_busy(r)));
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    wr_en_i = '0;
    resv_en_i = 1'b0;
  endtask

  task automatic wr(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en_i[k] = 1'b1;
    wr_addr_i[k*AW +: AW] = a;
    wr_data_i[k*DW +: DW] = d;
  endtask

  task automatic rd(input int r, input logic [AW-1:0] a);
    rd_addr_i[r*AW +: AW] = a;
  endtask

  initial begin
    cyc();
    cyc();
    chk("rst_ready", 64'(ready_o), 64'd0);

    // Sweep timing, with a write and a reservation attempted during CLEAR.
    rst_ni = 1'b1;
    wr(0, 5'd3, 32'hA);
    resv_en_i = 1'b1;
    resv_addr_i = 5'd3;
    rd(0, 5'd3);
    for (int i = 1; i <= 31; i++) begin
      cyc();
      chk("sweep_ready", 64'(ready_o), 64'(i == 31));
    end
    idle();
    #1;
    chk("clear_ign_data", 64'(rd_data_o[0 +: DW]), 64'd0);
    chk("clear_ign_busy", 64'(busy_o[0]), 64'd0);

    // Reset pulsed 10 cycles into a sweep restarts it.
    rst_ni = 1'b0;
    cyc();
    rst_ni = 1'b1;
    repeat (10) cyc();
    rst_ni = 1'b0;
    cyc();
    rst_ni = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      cyc();
      chk("resweep_ready", 64'(ready_o), 64'(i == 31));
    end

    wr(0, 5'd5, 32'hDEADBEEF);
    cyc();
    idle();
    rd(1, 5'd5);
    #1 chk("x5", 64'(rd_data_o[DW +: DW]), 64'hDEADBEEF);

    wr(1, 5'd0, 32'h1234);
    cyc();
    idle();
    rd(0, 5'd0);
    #1 chk("x0", 64'(rd_data_o[0 +: DW]), 64'd0);

    wr(0, 5'd7, 32'h11);
    wr(1, 5'd7, 32'h22);
    cyc();
    idle();
    rd(0, 5'd7);
    #1 chk("x7_prio", 64'(rd_data_o[0 +: DW]), 64'h22);

    resv_en_i = 1'b1;
    resv_addr_i = 5'd9;
    cyc();
    idle();
    rd(1, 5'd9);
    #1 chk("x9_resv", 64'(busy_o[1]), 64'd1);
    wr(0, 5'd9, 32'h55);
    cyc();
    idle();
    #1 chk("x9_wr_busy", 64'(busy_o[1]), 64'd0);
    chk("x9_wr_data", 64'(rd_data_o[DW +: DW]), 64'h55);
    resv_en_i = 1'b1;
    resv_addr_i = 5'd9;
    wr(1, 5'd9, 32'h55);
    cyc();
    idle();
    #1 chk("x9_both_busy", 64'(busy_o[1]), 64'd1);
    chk("x9_both_data", 64'(rd_data_o[DW +: DW]), 64'h55);

    wr(0, 5'd4, 32'h1);
    cyc();
    wr(0, 5'd4, 32'hF0);
    rd(0, 5'd4);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("x4_same", 64'(rd_data_o[0 +: DW]), 64'hF0);
`else
    chk("x4_same", 64'(rd_data_o[0 +: DW]), 64'h1);
`endif
    cyc();
    idle();
    #1 chk("x4_next", 64'(rd_data_o[0 +: DW]), 64'hF0);

    // Random traffic with small address ranges to force collisions.
    for (int n = 0; n < 3000; n++) begin
      rst_ni = ($urandom_range(0, 399) != 0);
      for (int k = 0; k < NW; k++) begin
        wr(k, 5'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 7 : 31)), $urandom);
        wr_en_i[k] = ($urandom_range(0, 2) != 0);
      end
      for (int r = 0; r < NR; r++) rd(r, 5'($urandom_range(0, 7)));
      resv_en_i = ($urandom_range(0, 1) != 0);
      resv_addr_i = 5'($urandom_range(0, 7));
      cyc();
    end
    rst_ni = 1'b1;
    idle();
    cyc();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the RISC-V core, successor to the single-write/dual-read file.
- Configurable read and write port counts.
- Per-register busy scoreboard, so issue logic can detect RAW hazards on in-flight writes.
- Clears its contents with a one-register-per-cycle sweep after reset instead of a flop-wide reset.
- Sits between decode/issue (reads, reservations) and writeback (writes).

Parameters:
RegWidth, 32, data width of each register
RegDepth, 32, number of architectural registers, including hardwired x0
NumRead, 2, number of independent read ports
NumWrite, 2, number of independent write ports
(Derived localparam AddrW = $clog2(RegDepth); not overridable.)

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_ni  input  1  reset, synchronous, active-low
ready_o  output  1  high once the clear sweep is complete; the file is usable
rd_addr_i  input  NumRead*AddrW  read addresses; port r occupies slice r
rd_data_o  output  NumRead*RegWidth  read data, combinational from rd_addr_i
busy_o  output  NumRead  busy (write pending) flag for each read port's address
wr_en_i  input  NumWrite  write enable per write port
wr_addr_i  input  NumWrite*AddrW  write addresses
wr_data_i  input  NumWrite*RegWidth  write data
resv_en_i  input  1  reserve the destination register of an issued instruction
resv_addr_i  input  AddrW  register being reserved

Behaviour:
- FSM states: CLEAR, RUN.
- Reset, i.e. rst_ni=0 sampled at posedge:
  - state <= CLEAR, sweep counter <= 1, all busy bits <= 0.
  - ready_o=0. Register contents are not touched by reset itself.
- CLEAR, with rst_ni=1:
  - Each cycle, write 0 to regs[counter] and increment the counter.
  - When counter == RegDepth-1 is cleared, go to RUN.
  - ready_o rises exactly RegDepth-1 cycles after the first cycle with rst_ni=1 (31 for the defaults).
  - Reset asserted mid-sweep restarts the counter at 1.
- In CLEAR:
  - wr_en_i and resv_en_i are ignored.
  - rd_data_o = 0 and busy_o = 0 on all ports.
- Reads (RUN):
  - rd_data_o[r] = regs[rd_addr_i[r]], or 0 when the address is 0.
  - Zero cycles of latency; the value reflects state before this edge's writes.
- Writes (RUN):
  - Port k with wr_en_i[k]=1 and address != 0 commits wr_data_i[k] at posedge.
  - Writes to x0 are discarded.
  - Several ports to the same address in one cycle: the highest port index wins.
- Scoreboard (RUN):
  - resv_en_i=1 with address != 0 sets busy[resv_addr_i].
  - Any committed write to address a clears busy[a].
  - Same cycle set and clear to the same address: set wins, because the reservation belongs to a younger instruction.
  - busy_o[r] = busy[rd_addr_i[r]], and 0 for x0.
  - Reserving an already-busy register leaves it busy. There is no count; a single write clears it.
- x0 has no storage. Reads of x0 return 0 and busy_o for x0 is 0 in all states.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-to-read bypass in RUN.
  - If any wr_en_i[k] targets a nonzero address equal to rd_addr_i[r], rd_data_o[r] returns the same-cycle wr_data_i of the highest matching k.
  - busy_o[r] is 0 for that address unless resv_en_i reserves the same address in that cycle.
  - Adds a combinational path from the write ports to rd_data_o.
- Undefined: no bypass. Reads return the pre-write value; busy_o shows the registered busy bit only.
- CLEAR-state behaviour is identical either way.

Test Plan:
- Reset low 2 cycles, then high -> ready_o=0 for exactly 31 cycles, then 1; all ports read 0. Reset pulsed at sweep cycle 10 -> ready_o delayed by a further 31 cycles.
- After ready, wr port0 x5=0xDEADBEEF -> next cycle rd port1 addr 5 reads 0xDEADBEEF. Write x0=0x1234 -> x0 reads 0.
- Ports 0 and 1 both write x7 (0x11, 0x22) in one cycle -> x7 reads 0x22.
- Reserve x9 -> busy_o=1 on a port reading 9. Write x9=0x55 -> busy_o=0 the next cycle. Reserve x9 and write x9 in the same cycle -> busy_o stays 1 and data is 0x55.
- Write x3=0xA during CLEAR -> ignored; after ready, x3 reads 0.
- REGFILE_BYPASS_EN: x4=0x1, then same-cycle write x4=0xF0 with read addr 4 -> rd_data_o=0xF0 that cycle. Without the macro -> reads 0x1 that cycle and 0xF0 the next.
